// File: rtl/mdu_iter.sv
// Iterative RV64M/RV32M multiply/divide unit: radix-2^MUL_STEP_BITS shift-add multiplier,
// restoring divider, one shared FSM. Optional macro MDU_PAIR_FUSE_EN adds a one-entry div/rem result cache.
module mdu_iter #(
  parameter int XLEN          = 64,
  parameter int MUL_STEP_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] src0,
  input  logic [XLEN-1:0] src1,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int X = XLEN;
  localparam int S = MUL_STEP_BITS;

  typedef enum logic [2:0] {IDLE, PREP, MUL, DIV, FIX, DONE} state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic            w_q, neg_q, rneg_q, out_valid_q;
  logic [X-1:0]    a_q, b_q, opnd_q, result_q;
  logic [2*X-1:0]  prod_q;
  logic [6:0]      cnt_q;

  function automatic logic [X-1:0] sext32(input logic [X-1:0] v);
    logic [X-1:0] r;
    r = v;
    for (int i = 32; i < X; i++) r[i] = v[31];
    return r;
  endfunction

  function automatic logic [X-1:0] zext32(input logic [X-1:0] v);
    logic [X-1:0] r;
    r = '0;
    r[31:0] = v[31:0];
    return r;
  endfunction

  logic            w_eff_s, signed_a_s, signed_b_s, sa_s, sb_s, zero_s, ovf_s, hit_s;
  logic [X-1:0]    ea_s, eb_s, mag_a_s, mag_b_s, minneg_s, spec_res_s, fix_res_s, quot_s, rem_s, hit_res_s;
  logic [X+S-1:0]  hi_ext_s, mc_ext_s, d_ext_s, sum_s;
  logic [2*X+S-1:0] mul_cat_s;
  logic [2*X-1:0]  mul_nx_s, div_nx_s, prod_fx_s, p_s;
  logic [2*X:0]    shifted_s;
  logic [X:0]      diff_s;

`ifdef MDU_PAIR_FUSE_EN
  logic            cv_q, c_sg_q, c_w_q;
  logic [X-1:0]    c_a_q, c_b_q, c_quo_q, c_rem_q;
`endif

  // Operand conditioning, special-case detection, per-cycle step and final fix-up
  always_comb begin
    w_eff_s    = (X == 64) ? w_q : 1'b0;
    signed_a_s = op_q[2] ? ~op_q[0] : (op_q[1:0] != 2'b11);
    signed_b_s = op_q[2] ? ~op_q[0] : ~op_q[1];
    ea_s = w_eff_s ? (signed_a_s ? sext32(a_q) : zext32(a_q)) : a_q;
    eb_s = w_eff_s ? (signed_b_s ? sext32(b_q) : zext32(b_q)) : b_q;
    sa_s = signed_a_s & ea_s[X-1];
    sb_s = signed_b_s & eb_s[X-1];
    mag_a_s = sa_s ? -ea_s : ea_s;
    mag_b_s = sb_s ? -eb_s : eb_s;

    minneg_s = '0;
    if (w_eff_s) begin
      minneg_s[31] = 1'b1;
      minneg_s = sext32(minneg_s);
    end else begin
      minneg_s[X-1] = 1'b1;
    end
    zero_s = op_q[2] & (eb_s == '0);
    ovf_s  = op_q[2] & ~op_q[0] & (ea_s == minneg_s) & (eb_s == '1);
    if (zero_s) spec_res_s = op_q[1] ? ea_s : '1;
    else        spec_res_s = op_q[1] ? '0 : ea_s;
    if (w_eff_s) spec_res_s = sext32(spec_res_s);

    hi_ext_s  = {{S{1'b0}}, prod_q[2*X-1:X]};
    mc_ext_s  = {{S{1'b0}}, opnd_q};
    d_ext_s   = {{X{1'b0}}, prod_q[S-1:0]};
    sum_s     = hi_ext_s + mc_ext_s * d_ext_s;
    mul_cat_s = {sum_s, prod_q[X-1:0]};
    mul_nx_s  = mul_cat_s[2*X+S-1:S];

    shifted_s = {prod_q, 1'b0};
    diff_s    = shifted_s[2*X:X] - {1'b0, opnd_q};
    if (!diff_s[X]) div_nx_s = {diff_s[X-1:0], shifted_s[X-1:1], 1'b1};
    else            div_nx_s = shifted_s[2*X-1:0];

    // A w-mode multiply only ran 32 bits' worth of shifts, so its product sits XLEN-32 bits high
    prod_fx_s = w_eff_s ? (prod_q >> (X - 32)) : prod_q;
    p_s       = neg_q ? -prod_fx_s : prod_fx_s;
    quot_s    = neg_q ? -prod_q[X-1:0] : prod_q[X-1:0];
    rem_s     = rneg_q ? -prod_q[2*X-1:X] : prod_q[2*X-1:X];
    if (w_eff_s) begin
      quot_s = sext32(quot_s);
      rem_s  = sext32(rem_s);
    end else begin
      quot_s = quot_s;
      rem_s  = rem_s;
    end
    if (op_q[2])                              fix_res_s = op_q[1] ? rem_s : quot_s;
    else if (w_eff_s || op_q[1:0] == 2'b00)   fix_res_s = p_s[X-1:0];
    else                                      fix_res_s = p_s[2*X-1:X];
    if (w_eff_s) fix_res_s = sext32(fix_res_s);

`ifdef MDU_PAIR_FUSE_EN
    hit_s = op_q[2] & cv_q & (c_a_q == a_q) & (c_b_q == b_q) & (c_sg_q == op_q[0]) & (c_w_q == w_eff_s);
    hit_res_s = op_q[1] ? c_rem_q : c_quo_q;
`else
    hit_s = 1'b0;
    hit_res_s = '0;
`endif
  end

  // Control FSM and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      w_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      opnd_q      <= '0;
      prod_q      <= '0;
      cnt_q       <= 7'd0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef MDU_PAIR_FUSE_EN
      cv_q <= 1'b0;
`endif
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
`ifdef MDU_PAIR_FUSE_EN
      cv_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            w_q     <= w;
            a_q     <= src0;
            b_q     <= src1;
            state_q <= PREP;
          end else begin
            state_q <= IDLE;
          end
        end
        PREP: begin
          neg_q  <= sa_s ^ sb_s;
          rneg_q <= sa_s;
          if (op_q[2]) begin
            opnd_q <= mag_b_s;
            prod_q <= {{X{1'b0}}, w_eff_s ? (mag_a_s << (X - 32)) : mag_a_s};
            cnt_q  <= w_eff_s ? 7'd32 : 7'(X);
          end else begin
            opnd_q <= mag_a_s;
            prod_q <= {{X{1'b0}}, mag_b_s};
            cnt_q  <= w_eff_s ? 7'(32 / S) : 7'(X / S);
          end
          if (zero_s || ovf_s || hit_s) begin
            result_q    <= hit_s ? hit_res_s : spec_res_s;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= op_q[2] ? DIV : MUL;
          end
        end
        MUL, DIV: begin
          prod_q  <= (state_q == MUL) ? mul_nx_s : div_nx_s;
          cnt_q   <= cnt_q - 7'd1;
          state_q <= (cnt_q == 7'd1) ? FIX : state_q;
        end
        FIX: begin
          result_q    <= fix_res_s;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
`ifdef MDU_PAIR_FUSE_EN
          if (op_q[2]) begin
            cv_q    <= 1'b1;
            c_a_q   <= a_q;
            c_b_q   <= b_q;
            c_sg_q  <= op_q[0];
            c_w_q   <= w_eff_s;
            c_quo_q <= quot_s;
            c_rem_q <= rem_s;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = (state_q != IDLE);
endmodule
